seq_muldiv_unit: RTL and testbench
==================================

// Module: seq_muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit for the cpu datapath. Replaces the single-cycle
//   a*b and a/b paths with a one-bit-per-cycle engine behind valid/ready handshakes.
//   Adds signed mode, full 2N-bit product, remainder and a divide-by-zero flag.
//   Sits beside the ALU. The cpu control FSM issues MUL/DIV operations and stalls until out_valid.
// PARAMETERS
//   DATA_WIDTH  16  operand width N; legal values are N >= 2
// PORTS
//   clk         in   1    clock; all state changes on the rising edge
//   rst_n       in   1    reset; synchronous, active-low
//   in_valid    in   1    operation request
//   in_ready    out  1    unit can accept an operation
//   op          in   2    00 MULU, 01 MULS, 10 DIVU, 11 DIVS
//   a           in   N    multiplicand / dividend
//   b           in   N    multiplier / divisor
//   out_valid   out  1    result valid
//   out_ready   in   1    consumer takes the result
//   result_lo   out  N    MUL: product[N-1:0]; DIV: quotient
//   result_hi   out  N    MUL: product[2N-1:N]; DIV: remainder
//   div_by_zero out  1    set with the result of a DIV when b==0
// BEHAVIOUR
//   States: IDLE, CALC, SIGN, DONE.
//   Registered state. in_ready = (state==IDLE); out_valid = (state==DONE).
//   Reset (rst_n==0 at a clk edge): state goes to IDLE, so in_ready=1 and out_valid=0.
//     result_lo, result_hi and div_by_zero are cleared to 0.
//     The counter and internal operands are cleared.
//     Reset overrides everything, including mid-CALC, SIGN or DONE.
//     An operation in flight is dropped and no result is produced.
//   Accept: on an edge in IDLE with in_valid=1, a, b and op are latched. Call this edge E0.
//     For signed ops, operand magnitudes and the result signs are latched.
//     in_valid while not IDLE is ignored; no queueing.
//   CALC: a counter runs 0..N-1 with one iteration per cycle.
//     MUL uses shift-add on a 2N-bit accumulator.
//     DIV uses restoring division: shift in the next dividend bit, trial-subtract the divisor, set the quotient bit.
//     At edge E_N, CALC goes to SIGN.
//   SIGN: two's-complement negation where required; edge E_{N+1} goes to DONE.
//     MULS: the 2N-bit product is negated iff the operand signs differ.
//     DIVS: the quotient is negated iff the signs differ.
//       The remainder takes the sign of the dividend.
//       Quotient truncates toward zero.
//     DIVS overflow (a=MIN, b=-1) gives quotient MIN, remainder 0, no flag.
//     Unsigned ops pass through SIGN unchanged; latency is the same for all ops.
//   Latency: out_valid is first high in the cycle after E_{N+1}.
//     That is N+1 edges after acceptance: 17 for N=16.
//   Divide by zero (op[1]=1, b==0): CALC and SIGN are bypassed; edge E1 goes to DONE.
//     result_lo = all ones, result_hi = a (unmodified, either sign), div_by_zero = 1.
//     div_by_zero is 0 for every other result.
//   DONE: result_lo, result_hi and div_by_zero hold stable until out_valid && out_ready.
//     On that edge the state goes to IDLE. The result registers keep their last values.
//     in_ready rises the cycle after the handshake; no same-cycle re-accept.
//   All arithmetic is modulo 2^N per output word; no other status flags.
// TESTING
//   1. N=16, MULU a=300 b=200 -> lo=0xEA60 hi=0x0000, dbz=0.
//      out_valid rises exactly 17 cycles after accept.
//   2. MULS a=0xFFFD (-3) b=0x0005 -> {hi,lo}=0xFFFF_FFF1.
//      MULU 0xFFFF*0xFFFF -> hi=0xFFFE lo=0x0001.
//   3. DIVU 100/7 -> lo=14 hi=2. DIVS 0xFFF9/0x0002 -> lo=0xFFFD hi=0xFFFF.
//      DIVS 0x8000/0xFFFF -> lo=0x8000 hi=0x0000 dbz=0.
//   4. DIVU 1234/0 -> out_valid 1 cycle after accept: lo=0xFFFF hi=0x04D2 dbz=1.
//      DIVS 0xFF00/0 -> hi=0xFF00.
//   5. out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, extra in_valid ignored.
//      Then out_ready=1 -> IDLE; in_ready=1 on the next cycle.
//   6. rst_n=0 for one edge at the 5th CALC cycle -> out_valid=0, in_ready=1, results=0.
//      A new MULU 3*4 then returns lo=12 after 17 cycles.

Source files
------------

// File: rtl/seq_muldiv_unit.sv
// Iterative multiply/divide engine: shift-add multiply and restoring divide,
// one bit per cycle, with sign correction and a divide-by-zero shortcut.
module seq_muldiv_unit #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result_lo,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  div_by_zero
);

  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg;
  logic [2*N-1:0]  acc_reg;
  logic [N-1:0]    b_mag_reg;
  logic            is_div_reg, dbz_reg, neg_res_reg, neg_rem_reg;

  logic            a_neg, b_neg;
  logic [N-1:0]    a_mag, b_mag;
  logic [N:0]      mul_sum;
  logic [2*N-1:0]  mul_step;
  logic [N:0]      div_shift, div_trial;
  logic [2*N-1:0]  div_step;
  logic [N-1:0]    acc_lo, acc_hi, quot_fix, rem_fix;
  logic [2*N-1:0]  prod_fix;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);

  assign a_neg = op[0] & a[N-1];
  assign b_neg = op[0] & b[N-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign acc_lo = acc_reg[N-1:0];
  assign acc_hi = acc_reg[2*N-1:N];

  // Multiply: low half holds the multiplier, shifted out LSB first; the
  // (N+1)-bit sum keeps the carry that shifts into the top of the product.
  assign mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_reg[0] ? b_mag_reg : {N{1'b0}})};
  assign mul_step = {mul_sum, acc_reg[N-1:1]};

  // Divide: high half is the partial remainder, low half the dividend that
  // turns into the quotient. A clear bit N after the trial means no borrow.
  assign div_shift = {acc_hi, acc_reg[N-1]};
  assign div_trial = div_shift - {1'b0, b_mag_reg};
  assign div_step  = div_trial[N] ? {div_shift[N-1:0], acc_reg[N-2:0], 1'b0}
                                  : {div_trial[N-1:0], acc_reg[N-2:0], 1'b1};

  assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
  assign quot_fix = neg_res_reg ? -acc_lo : acc_lo;
  assign rem_fix  = neg_rem_reg ? -acc_hi : acc_hi;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = CALC;
      CALC: begin
        if (dbz_reg)                          state_next = DONE;
        else if (count_reg == CW'(N - 1))     state_next = SIGN;
      end
      SIGN: state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg   <= '0;
      acc_reg     <= '0;
      b_mag_reg   <= '0;
      is_div_reg  <= 1'b0;
      dbz_reg     <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          acc_reg     <= {{N{1'b0}}, a_mag};
          b_mag_reg   <= b_mag;
          is_div_reg  <= op[1];
          dbz_reg     <= op[1] && (b == '0);
          neg_res_reg <= a_neg ^ b_neg;
          neg_rem_reg <= a_neg;
          count_reg   <= '0;
        end
        CALC: begin
          if (dbz_reg) begin
            // Re-negating the magnitude restores the dividend bit pattern.
            result_lo   <= '1;
            result_hi   <= neg_rem_reg ? -acc_lo : acc_lo;
            div_by_zero <= 1'b1;
          end else begin
            acc_reg   <= is_div_reg ? div_step : mul_step;
            count_reg <= count_reg + 1'b1;
          end
        end
        SIGN: begin
          if (is_div_reg) begin
            result_lo <= quot_fix;
            result_hi <= rem_fix;
          end else begin
            {result_hi, result_lo} <= prod_fix;
          end
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Directed bench for seq_muldiv_unit: hand-computed results, latency,
// DONE back-pressure and mid-calculation reset.
module tb_seq_muldiv_unit;

  localparam int N = 16;
  localparam logic [1:0] MULU = 2'b00, MULS = 2'b01, DIVU = 2'b10, DIVS = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   op = 2'b00;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] result_lo, result_hi;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;

  seq_muldiv_unit #(.DATA_WIDTH(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp_v);
    end
  endtask

  // Present one request and return #1 after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Edges counted after the accepting edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [N-1:0] x,
                     input logic [N-1:0] y, input logic [N-1:0] exp_lo,
                     input logic [N-1:0] exp_hi, input logic exp_dbz, input int exp_lat);
    int lat;
    issue(o, x, y);
    wait_valid(lat);
    $display("txn %s op=%0d a=0x%04h b=0x%04h -> lo=0x%04h hi=0x%04h dbz=%0b lat=%0d",
             tag, o, x, y, result_lo, result_hi, div_by_zero, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_lo"}, result_lo, exp_lo);
    check({tag, "_hi"}, result_hi, exp_hi);
    check({tag, "_dbz"}, div_by_zero, exp_dbz);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_rdy_after"}, in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_lo", result_lo, 16'h0000);
    check("rst_hi", result_hi, 16'h0000);
    check("rst_dbz", div_by_zero, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    run("mulu_300x200", MULU, 16'd300, 16'd200, 16'hEA60, 16'h0000, 1'b0, 17);
    run("muls_m3x5",    MULS, 16'hFFFD, 16'h0005, 16'hFFF1, 16'hFFFF, 1'b0, 17);
    run("mulu_max",     MULU, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17);
    run("divu_100_7",   DIVU, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
    run("divs_m7_2",    DIVS, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 17);
    run("divs_7_m2",    DIVS, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 17);
    run("divs_ovf",     DIVS, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17);
    run("divu_by0",     DIVU, 16'd1234, 16'd0, 16'hFFFF, 16'h04D2, 1'b1, 1);
    run("divs_by0",     DIVS, 16'hFF00, 16'h0000, 16'hFFFF, 16'hFF00, 1'b1, 1);
    run("muls_after0",  MULS, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17);

    // Hold DONE with back-pressure while another request is waved at the unit.
    issue(MULU, 16'd7, 16'd9);
    wait_valid(lat);
    check("hold_lat", lat, 17);
    for (int i = 0; i < 10; i++) begin
      op = DIVU; a = 16'd5; b = 16'd0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_valid", i), out_valid, 1'b1);
      check($sformatf("hold%0d_ready", i), in_ready, 1'b0);
      check($sformatf("hold%0d_lo", i), result_lo, 16'd63);
      check($sformatf("hold%0d_dbz", i), div_by_zero, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("hold_release_ready", in_ready, 1'b1);
    check("hold_release_valid", out_valid, 1'b0);
    check("hold_keep_lo", result_lo, 16'd63);
    repeat (3) @(posedge clk);
    #1;
    check("hold_no_queue", out_valid, 1'b0);
    $display("txn hold MULU 7*9 lo=0x%04h held 10 cycles", result_lo);

    // Reset during the fifth CALC cycle drops the operation.
    issue(MULU, 16'd300, 16'd200);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_lo", result_lo, 16'h0000);
    check("midrst_hi", result_hi, 16'h0000);
    check("midrst_dbz", div_by_zero, 1'b0);
    $display("txn midrst in_ready=%0b out_valid=%0b", in_ready, out_valid);
    run("mulu_3x4", MULU, 16'd3, 16'd4, 16'd12, 16'd0, 1'b0, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
